// File: rtl/icache_dm_line.sv
// Direct-mapped instruction cache with multi-word lines and a line-refill FSM.
// Define ICACHE_CRITICAL_WORD_FIRST_EN to refill from the requested word and forward it early.
//
// state  | meaning
// IDLE   | lookups served combinationally; a miss launches a refill
// REFILL | fetching a full line from RC, one word per rdy_i pulse
module icache_dm_line #(
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 2,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              flush_i,
   input  logic              en_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              rdy_o,
   output logic [31:0]       inst_o,
   output logic              en_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic              rdy_i,
   input  logic [31:0]       inst_i
);
   localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam int LINE_W = TAG_W + INDEX_W;
   localparam int LINES  = 1 << INDEX_W;
   localparam int WORDS  = 1 << (INDEX_W + OFFSET_W);

   typedef enum logic {IDLE, REFILL} state_t;
   state_t state, state_nxt;

   logic [31:0]         data_mem [WORDS];
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [LINES-1:0]    valid;
   logic                flush_pend;
   logic [OFFSET_W-1:0] cnt;

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_idx;
   logic [OFFSET_W-1:0] req_off_in;
   logic [LINE_W-1:0]   fill_line;
   logic [INDEX_W-1:0]  fill_idx;
   logic [OFFSET_W-1:0] fill_off, fill_off_nxt, start_off;
   logic                hit_raw, miss_go, word_go, last_word;
   logic                unused_addr_lsb;

   assign req_tag      = addr_i[ADDR_W-1 -: TAG_W];
   assign req_idx      = addr_i[OFFSET_W+2 +: INDEX_W];
   assign req_off_in   = addr_i[2 +: OFFSET_W];
   assign unused_addr_lsb = ^addr_i[1:0];

   // The outstanding RC address doubles as the refill line base and word pointer.
   assign fill_line    = addr_o[ADDR_W-1 -: LINE_W];
   assign fill_idx     = addr_o[OFFSET_W+2 +: INDEX_W];
   assign fill_off     = addr_o[2 +: OFFSET_W];
   assign fill_off_nxt = fill_off + OFFSET_W'(1);

   assign hit_raw   = en_i && valid[req_idx] && (tag_mem[req_idx] == req_tag);
   assign miss_go   = rdy && (state == IDLE) && en_i && !hit_raw;
   assign word_go   = rdy && (state == REFILL) && rdy_i;
   assign last_word = word_go && (cnt == '1);

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   logic [OFFSET_W-1:0] req_off;
   logic                fwd;

   assign start_off = req_off_in;
   // The requested word arrives exactly once per refill, so forwarding is one-shot.
   assign fwd = word_go && (fill_off == req_off) && en_i &&
                (addr_i[ADDR_W-1:2] == {fill_line, req_off});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         req_off <= '0;
      else if (miss_go)
         req_off <= req_off_in;
   end
`else
   logic fwd;

   assign start_off = '0;
   assign fwd       = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      rdy_o     = 1'b0;
      inst_o    = '0;
      case (state)
         IDLE: begin
            if (rdy && hit_raw) begin
               rdy_o  = 1'b1;
               inst_o = data_mem[{req_idx, req_off_in}];
            end
            if (miss_go)
               state_nxt = REFILL;
         end
         REFILL: begin
            if (fwd) begin
               rdy_o  = 1'b1;
               inst_o = inst_i;
            end
            if (last_word)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= '0;
         flush_pend <= 1'b0;
         cnt        <= '0;
         en_o       <= 1'b0;
         addr_o     <= '0;
      end else if (rdy) begin
         state <= state_nxt;
         if (flush_i)
            valid <= '0;
         if (miss_go) begin
            valid[req_idx] <= 1'b0;
            cnt            <= '0;
            en_o           <= 1'b1;
            addr_o         <= {req_tag, req_idx, start_off, 2'b00};
         end
         if (state == REFILL) begin
            if (flush_i)
               flush_pend <= 1'b1;
            if (word_go) begin
               cnt    <= cnt + OFFSET_W'(1);
               addr_o <= {fill_line, fill_off_nxt, 2'b00};
            end
            // A flush seen at any point of the refill leaves the line invalid.
            if (last_word) begin
               en_o       <= 1'b0;
               flush_pend <= 1'b0;
               if (!flush_pend && !flush_i)
                  valid[fill_idx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (miss_go)
         tag_mem[req_idx] <= req_tag;
      if (word_go)
         data_mem[{fill_idx, fill_off}] <= inst_i;
   end

endmodule

// File: tb/tb_icache_dm_line.sv
// Randomized self-checking bench for icache_dm_line; acts as IF and as the RC word server.
module tb_icache_dm_line;
   localparam int IDX_W = 6;
   localparam int OFF_W = 2;
   localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
   localparam int LINES = 1 << IDX_W;
   localparam int LINE_WORDS = 1 << OFF_W;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, rdy, flush_i, en_i, rdy_i;
   logic [31:0] addr_i, inst_i;
   logic        rdy_o, en_o;
   logic [31:0] inst_o, addr_o;

   icache_dm_line #(.INDEX_W(IDX_W), .OFFSET_W(OFF_W), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush_i(flush_i), .en_i(en_i),
      .addr_i(addr_i), .rdy_o(rdy_o), .inst_o(inst_o), .en_o(en_o),
      .addr_o(addr_o), .rdy_i(rdy_i), .inst_i(inst_i)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int fixed_lat = -1;

   // Reference cache contents: which line holds which tag; data always equals RAM.
   logic [LINES-1:0] m_valid = '0;
   logic [TAG_W-1:0] m_tag [LINES];

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (w >= 32'h100 && w <= 32'h10C)
         return ((w - 32'h100) / 4 + 1) * 32'h11;
      return (w * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   task automatic idle_flush();
      @(negedge clk);
      en_i = 1'b0; rdy_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      m_valid = '0;
   endtask

   // flush_at: -2 = flush together with the miss, k>=0 = flush on k-th RC word, -1 = none.
   task automatic do_fetch(input logic [31:0] a, input int flush_at, input int stall_at,
                           input int rst_at);
      int               idx, off, start, lat;
      logic [TAG_W-1:0] tg;
      logic [31:0]      base, exp_addr;
      logic             flushed;
      idx = int'(a[OFF_W+2 +: IDX_W]);
      off = int'(a[2 +: OFF_W]);
      tg  = a[31 -: TAG_W];
      @(negedge clk);
      en_i = 1'b1; addr_i = a; rdy_i = 1'b0; flush_i = (flush_at == -2); #1;
      if (m_valid[idx] && m_tag[idx] == tg) begin
         chk_eq("hit_rdy_o", rdy_o, 1);
         chk_eq("hit_inst_o", inst_o, mem(a));
         chk_eq("hit_en_o", en_o, 0);
         en_i = 1'b0; flush_i = 1'b0;
         return;
      end
      chk_eq("miss_rdy_o", rdy_o, 0);
      chk_eq("miss_inst_o", inst_o, 0);
      flushed = 1'b0;
      if (flush_at == -2) m_valid = '0;
      m_valid[idx] = 1'b0;
      m_tag[idx]   = tg;
      base  = a & ~32'((1 << (OFF_W + 2)) - 1);
      start = CWF ? off : 0;
      for (int k = 0; k < LINE_WORDS; k++) begin
         exp_addr = base | 32'(((start + k) % LINE_WORDS) << 2);
         lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
         if (k == rst_at) begin
            @(negedge clk);
            flush_i = 1'b0; rdy_i = 1'b0; #1;
            rst_n = 1'b0; #1;
            chk_eq("rst_en_o", en_o, 0);
            chk_eq("rst_addr_o", addr_o, 0);
            chk_eq("rst_rdy_o", rdy_o, 0);
            m_valid = '0;
            en_i = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         repeat (lat) begin
            @(negedge clk);
            flush_i = 1'b0; rdy_i = 1'b0; #1;
            chk_eq("wait_en_o", en_o, 1);
            chk_eq("wait_addr_o", addr_o, exp_addr);
            chk_eq("wait_rdy_o", rdy_o, 0);
         end
         if (k == stall_at) begin
            repeat (3) begin
               @(negedge clk);
               rdy = 1'b0; rdy_i = 1'b1; inst_i = 32'hDEAD_BEEF; flush_i = 1'b0; #1;
               chk_eq("stall_en_o", en_o, 1);
               chk_eq("stall_addr_o", addr_o, exp_addr);
               chk_eq("stall_rdy_o", rdy_o, 0);
            end
         end
         @(negedge clk);
         rdy = 1'b1; rdy_i = 1'b1; inst_i = mem(exp_addr); flush_i = (k == flush_at); #1;
         if (k == flush_at) begin
            m_valid = '0;
            flushed = 1'b1;
         end
         chk_eq("word_en_o", en_o, 1);
         chk_eq("word_addr_o", addr_o, exp_addr);
         if (CWF && k == 0) begin
            chk_eq("fwd_rdy_o", rdy_o, 1);
            chk_eq("fwd_inst_o", inst_o, mem(a));
         end else begin
            chk_eq("word_rdy_o", rdy_o, 0);
         end
      end
      @(negedge clk);
      rdy_i = 1'b0; flush_i = 1'b0; #1;
      chk_eq("done_en_o", en_o, 0);
      if (!flushed) m_valid[idx] = 1'b1;
      chk_eq("post_rdy_o", rdy_o, 32'(m_valid[idx]));
      if (m_valid[idx]) chk_eq("post_inst_o", inst_o, mem(a));
      en_i = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      rst_n = 1'b0; rdy = 1'b1; flush_i = 1'b0; en_i = 1'b1; addr_i = 32'h104;
      rdy_i = 1'b0; inst_i = '0;
      repeat (3) @(negedge clk);
      #1;
      chk_eq("reset_en_o", en_o, 0);
      chk_eq("reset_addr_o", addr_o, 0);
      chk_eq("reset_rdy_o", rdy_o, 0);
      chk_eq("reset_inst_o", inst_o, 0);
      en_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      fixed_lat = 2;
      do_fetch(32'h104, -1, -1, -1);
      do_fetch(32'h108, -1, -1, -1);
      do_fetch(32'h10C, -1, -1, -1);
      fixed_lat = -1;

      @(negedge clk);
      rdy = 1'b0; en_i = 1'b1; addr_i = 32'h104; #1;
      chk_eq("frozen_rdy_o", rdy_o, 0);
      chk_eq("frozen_inst_o", inst_o, 0);
      @(negedge clk);
      rdy = 1'b1; en_i = 1'b0;

      do_fetch(32'h1104, -1, -1, -1);
      do_fetch(32'h104, -1, -1, -1);
      do_fetch(32'h200, 1, -1, -1);
      do_fetch(32'h200, -1, -1, -1);
      do_fetch(32'h300, -1, 2, -1);
      do_fetch(32'h300, -1, -1, -1);
      do_fetch(32'h400, -1, -1, 2);
      do_fetch(32'h400, -1, -1, -1);
      do_fetch(32'h200, -1, -1, -1);
      do_fetch(32'h508, -2, -1, -1);
      do_fetch(32'h200, -1, -1, -1);
      do_fetch(32'h508, -1, -1, -1);

      for (int i = 0; i < 80; i++) begin
         a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         r = int'($urandom_range(0, 9));
         if (r == 0) idle_flush();
         do_fetch(a, (r == 1) ? int'($urandom_range(0, 3)) : -1,
                     (r == 2) ? int'($urandom_range(0, 3)) : -1,
                     (r == 3) ? int'($urandom_range(0, 3)) : -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
